regfile_write_sequencer: RTL and testbench
==========================================

// Module: regfile_write_sequencer
// PURPOSE
//  Write-back producer for the 16x16 register file. Sits between the MEM/WB stage and the register file write ports.
//  Accepts one- or two-result write-backs (ALU result; MUL/DIV low+high) over valid/ready and buffers them in a FIFO.
//  Issues them in order onto WriteReg1/2, WriteData1/2, RegWrite and WriteOP2.
//  Keeps a pending-write mask and bypass data so decode can forward or stall on RAW hazards.
// PARAMETERS
//  DATA_W  16  register data width
//  ADDR_W  4   register address width (2**ADDR_W registers)
//  DEPTH   2   FIFO entries; power of two, >=2
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous, active-high reset
//  in_valid    in   1        write-back request present
//  in_ready    out  1        FIFO can accept this cycle
//  in_rd1      in   ADDR_W   primary destination register
//  in_data1    in   DATA_W   primary result
//  in_wr2      in   1        second result present
//  in_rd2      in   ADDR_W   secondary destination register
//  in_data2    in   DATA_W   secondary result
//  wb_en       in   1        1 = issue head entry this cycle; 0 = hold (freeze)
//  RegWrite    out  1        register file write strobe, port 1
//  WriteOP2    out  1        register file port-2 enable (only with RegWrite)
//  WriteReg1   out  ADDR_W   port-1 address
//  WriteData1  out  DATA_W   port-1 data
//  WriteReg2   out  ADDR_W   port-2 address
//  WriteData2  out  DATA_W   port-2 data
//  pending     out  2**ADDR_W  bit r = a write to Rr is queued or on the write ports
//  chk_reg1    in   ADDR_W   bypass lookup address A
//  chk_hit1    out  1        1 = Rr in pending
//  chk_data1   out  DATA_W   youngest in-flight value for chk_reg1 (0 when no hit)
//  chk_reg2/chk_hit2/chk_data2  same as chk_reg1/chk_hit1/chk_data1 for lookup B
//  count       out  clog2(DEPTH)+1  occupied FIFO entries
// BEHAVIOUR
//  Reset (rst=1 at an edge): FIFO emptied, count=0, RegWrite=0, WriteOP2=0, all Write* addr/data=0, pending=0.
//   in_ready=0 while rst=1. Mid-operation reset discards all queued and output-stage writes with no partial commit.
//  Accept: when in_valid && in_ready at an edge, push {rd1,data1,wr2,rd2,data2}. in_ready = (count<DEPTH) && !rst.
//   It does not depend on wb_en or same-cycle pop. in_valid && !in_ready leaves the request unaccepted.
//  Same-address collapse: wr2=1 with rd1==rd2 is stored as a single write of data2 to rd2 with wr2=0
//   (port 2 wins, as in the register file).
//  Issue: at an edge with wb_en=1 and count>0, pop the head into the registered output stage.
//   RegWrite=1 for exactly the next cycle. WriteOP2=wr2 of that entry.
//   Otherwise RegWrite=0 and WriteOP2=0 next cycle; addr/data hold their last values.
//  Latency: a request accepted at edge E into an empty FIFO with wb_en=1 is popped at E+1.
//   It drives the ports during cycle E+1..E+2 and commits in the register file at E+2. Throughput: 1 entry per cycle.
//  Simultaneous push+pop: allowed when count<DEPTH; count unchanged. A full FIFO never pushes, even if popping.
//  Order: strict FIFO; the output stage always holds the oldest uncommitted write.
//  pending: bit r = OR over valid FIFO entries and the output stage (while RegWrite=1) targeting Rr on either port.
//   It is built from state only; there is no combinational path from in_*.
//   A bit clears after the edge committing the last in-flight write to Rr. Multiple queued writes to one Rr keep it set.
//  Bypass: chk_hitN = pending[chk_regN]. chk_dataN = value from the youngest matching write.
//   Priority: newest FIFO entry > older entries > output stage; within an entry, port 2 > port 1.
//   Path is combinational from chk_regN and state only.
//  Widths: data passed unmodified; no arithmetic on data; count wraps never (saturates by in_ready).
// TESTING
//  1 Reset: hold rst 2 cycles mid-stream with 2 queued -> RegWrite=0, pending=0, count=0, no write reaches regfile.
//  2 Single: push rd1=3,data1=16'hBEEF,wr2=0, wb_en=1 -> RegWrite=1,WriteReg1=3 two edges later.
//     pending[3]=1 for 2 cycles, then 0.
//  3 Dual/collapse: push rd1=5,data1=16'h0011,wr2=1,rd2=15,data2=16'h0022 -> both ports, WriteOP2=1.
//     Then push rd1=rd2=7 (data 1/2) -> one write R7=2, WriteOP2=0.
//  4 Full/backpressure: wb_en=0, push 3 back-to-back.
//     -> count=2, in_ready=0, third held; raise wb_en -> all 3 issue in order.
//  5 Bypass: queue R4=16'h0A, then R4=16'h0B, wb_en=0 -> chk_reg1=4 gives hit=1,data=16'h0B.
//     chk_reg2=9 gives hit=0,data=0.
//  6 Push+pop at count=1 with wb_en=1 for 10 cycles -> count stays 1, one RegWrite per cycle, order preserved.

Source files
------------

// File: rtl/regfile_write_sequencer_if.sv
// Write-back request channel into the register-file write sequencer.
// A request is taken at a rising edge where in_valid and in_ready are both high.
interface regfile_write_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rd1;
    logic [DATA_W-1:0] in_data1;
    logic              in_wr2;
    logic [ADDR_W-1:0] in_rd2;
    logic [DATA_W-1:0] in_data2;

    modport master (
        output in_valid, in_rd1, in_data1, in_wr2, in_rd2, in_data2,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd1, in_data1, in_wr2, in_rd2, in_data2,
        output in_ready
    );
endinterface

// File: rtl/regfile_write_sequencer.sv
// Buffers one- or two-result write-backs in a FIFO and issues them in order to the register file.
// Also tracks in-flight destinations so decode can forward data or stall on RAW hazards.
module regfile_write_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    regfile_write_sequencer_if.slave    wb,
    input  logic                        wb_en,
    output logic                        RegWrite,
    output logic                        WriteOP2,
    output logic [ADDR_W-1:0]           WriteReg1,
    output logic [DATA_W-1:0]           WriteData1,
    output logic [ADDR_W-1:0]           WriteReg2,
    output logic [DATA_W-1:0]           WriteData2,
    output logic [2**ADDR_W-1:0]        pending,
    input  logic [ADDR_W-1:0]           chk_reg1,
    output logic                        chk_hit1,
    output logic [DATA_W-1:0]           chk_data1,
    input  logic [ADDR_W-1:0]           chk_reg2,
    output logic                        chk_hit2,
    output logic [DATA_W-1:0]           chk_data2,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] rd1;
        logic [DATA_W-1:0] data1;
        logic              wr2;
        logic [ADDR_W-1:0] rd2;
        logic [DATA_W-1:0] data2;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [CntW-1:0]   count_q;
    entry_t            new_entry;
    entry_t            head;
    logic              push;
    logic              pop;

    assign wb.in_ready = (count_q < CntW'(DEPTH)) && !rst;
    assign push        = wb.in_valid && wb.in_ready;
    assign pop         = wb_en && (count_q != '0);
    assign head        = mem_q[rd_ptr_q];
    assign count       = count_q;

    // Both ports to one register: the register file lets port 2 win, so keep only that write.
    always_comb begin
        new_entry = '{rd1: wb.in_rd1, data1: wb.in_data1, wr2: wb.in_wr2,
                      rd2: wb.in_rd2, data2: wb.in_data2};
        if (wb.in_wr2 && (wb.in_rd1 == wb.in_rd2)) begin
            new_entry.data1 = wb.in_data2;
            new_entry.wr2   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            RegWrite   <= 1'b0;
            WriteOP2   <= 1'b0;
            WriteReg1  <= '0;
            WriteData1 <= '0;
            WriteReg2  <= '0;
            WriteData2 <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= new_entry;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PtrW'(1);
                WriteReg1  <= head.rd1;
                WriteData1 <= head.data1;
                WriteReg2  <= head.rd2;
                WriteData2 <= head.data2;
            end
            RegWrite <= pop;
            WriteOP2 <= pop && head.wr2;
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Walk oldest to newest so the last match is the youngest value.
    logic [ADDR_W-1:0] qry [2];
    logic [DATA_W-1:0] byp [2];
    logic [PtrW-1:0]   idx;

    assign qry[0] = chk_reg1;
    assign qry[1] = chk_reg2;

    always_comb begin
        pending = '0;
        byp[0]  = '0;
        byp[1]  = '0;
        idx     = '0;
        if (RegWrite) begin
            pending[WriteReg1] = 1'b1;
            if (WriteOP2) pending[WriteReg2] = 1'b1;
            for (int unsigned q = 0; q < 2; q++) begin
                if (WriteReg1 == qry[q]) byp[q] = WriteData1;
                if (WriteOP2 && (WriteReg2 == qry[q])) byp[q] = WriteData2;
            end
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PtrW'(k);
            if (CntW'(k) < count_q) begin
                pending[mem_q[idx].rd1] = 1'b1;
                if (mem_q[idx].wr2) pending[mem_q[idx].rd2] = 1'b1;
                for (int unsigned q = 0; q < 2; q++) begin
                    if (mem_q[idx].rd1 == qry[q]) byp[q] = mem_q[idx].data1;
                    if (mem_q[idx].wr2 && (mem_q[idx].rd2 == qry[q])) byp[q] = mem_q[idx].data2;
                end
            end
        end
    end

    assign chk_hit1  = pending[chk_reg1];
    assign chk_hit2  = pending[chk_reg2];
    assign chk_data1 = byp[0];
    assign chk_data2 = byp[1];
endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed bench for regfile_write_sequencer; issued writes are checked against a scoreboard queue.
module tb_regfile_write_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic        RegWrite, WriteOP2;
    logic [3:0]  WriteReg1, WriteReg2;
    logic [15:0] WriteData1, WriteData2;
    logic [15:0] pending;
    logic [3:0]  chk_reg1, chk_reg2;
    logic        chk_hit1, chk_hit2;
    logic [15:0] chk_data1, chk_data2;
    logic [1:0]  count;

    int errors = 0;
    int checks = 0;
    int writes_seen = 0;
    int seen0;

    // {op2, rd1, data1, rd2, data2}; port-2 fields zeroed when op2 is 0
    typedef logic [40:0] wr_t;
    wr_t exp_q[$];

    regfile_write_sequencer_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    regfile_write_sequencer #(.DATA_W(16), .ADDR_W(4), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb         (bus),
        .wb_en      (wb_en),
        .RegWrite   (RegWrite),
        .WriteOP2   (WriteOP2),
        .WriteReg1  (WriteReg1),
        .WriteData1 (WriteData1),
        .WriteReg2  (WriteReg2),
        .WriteData2 (WriteData2),
        .pending    (pending),
        .chk_reg1   (chk_reg1),
        .chk_hit1   (chk_hit1),
        .chk_data1  (chk_data1),
        .chk_reg2   (chk_reg2),
        .chk_hit2   (chk_hit2),
        .chk_data2  (chk_data2),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic wr_t mk(input logic op2, input logic [3:0] rd1, input logic [15:0] d1,
                               input logic [3:0] rd2, input logic [15:0] d2);
        if (op2) return {1'b1, rd1, d1, rd2, d2};
        return {1'b0, rd1, d1, 4'h0, 16'h0000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h required=%0h", tag, got, exp);
        end
    endtask

    // Drives a request until accepted and records the write the register file should see.
    task automatic push(input logic [3:0] rd1, input logic [15:0] d1, input logic wr2,
                        input logic [3:0] rd2, input logic [15:0] d2);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_rd1   = rd1;
        bus.in_data1 = d1;
        bus.in_wr2   = wr2;
        bus.in_rd2   = rd2;
        bus.in_data2 = d2;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("push_timeout", 32'(n < 100), 32'd1);
        @(posedge clk);
        if (wr2 && rd1 == rd2) exp_q.push_back(mk(1'b0, rd2, d2, 4'h0, 16'h0));
        else                   exp_q.push_back(mk(wr2, rd1, d1, rd2, d2));
        #1;
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && RegWrite) begin
            wr_t got;
            wr_t exp;
            writes_seen++;
            got = mk(WriteOP2, WriteReg1, WriteData1, WriteReg2, WriteData2);
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL wb_unexpected got=%0h required=no write", got);
            end
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                checks++;
                assert (got === exp) else begin
                    errors++;
                    $error("FAIL wb_data got=%0h required=%0h", got, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wb_en = 1'b0;
        chk_reg1 = 4'h0;
        chk_reg2 = 4'h0;
        bus.in_valid = 1'b0;
        bus.in_rd1 = '0; bus.in_data1 = '0; bus.in_wr2 = 1'b0; bus.in_rd2 = '0; bus.in_data2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Mid-stream reset with two queued writes
        push(4'd1, 16'h1111, 1'b0, 4'd0, 16'h0);
        push(4'd2, 16'h2222, 1'b1, 4'd3, 16'h3333);
        @(negedge clk);
        chk("t1_count", 32'(count), 32'd2);
        chk("t1_pending", 32'(pending), 32'h000E);
        @(posedge clk); #1;
        rst = 1'b1;
        wb_en = 1'b1;
        @(negedge clk);
        chk("t1_in_ready_rst", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        seen0 = writes_seen;
        @(negedge clk);
        chk("t1_count_clr", 32'(count), 32'd0);
        chk("t1_pending_clr", 32'(pending), 32'd0);
        chk("t1_regwrite", 32'(RegWrite), 32'd0);
        repeat (4) @(negedge clk);
        chk("t1_no_writes", 32'(writes_seen - seen0), 32'd0);

        // Single write latency and pending lifetime
        push(4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0);
        @(negedge clk);
        chk("t2_pending_q", 32'(pending), 32'h0008);
        chk("t2_regwrite_early", 32'(RegWrite), 32'd0);
        @(negedge clk);
        chk("t2_regwrite", 32'(RegWrite), 32'd1);
        chk("t2_writereg1", 32'(WriteReg1), 32'd3);
        chk("t2_pending_out", 32'(pending), 32'h0008);
        @(negedge clk);
        chk("t2_pending_clr", 32'(pending), 32'd0);
        chk("t2_regwrite_off", 32'(RegWrite), 32'd0);

        // Dual write then same-address collapse
        push(4'd5, 16'h0011, 1'b1, 4'd15, 16'h0022);
        push(4'd7, 16'h0001, 1'b1, 4'd7, 16'h0002);
        repeat (4) @(negedge clk);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);
        chk("t3_pending", 32'(pending), 32'd0);

        // Backpressure with a full FIFO
        wb_en = 1'b0;
        push(4'd8, 16'h00A1, 1'b0, 4'd0, 16'h0);
        push(4'd9, 16'h00B2, 1'b1, 4'd10, 16'h00B3);
        bus.in_valid = 1'b1;
        bus.in_rd1 = 4'd11; bus.in_data1 = 16'h00C3; bus.in_wr2 = 1'b0;
        @(negedge clk);
        chk("t4_count_full", 32'(count), 32'd2);
        chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_count_hold", 32'(count), 32'd2);
        chk("t4_third_held", 32'(exp_q.size()), 32'd2);
        @(posedge clk); #1 wb_en = 1'b1;
        push(4'd11, 16'h00C3, 1'b0, 4'd0, 16'h0);
        repeat (5) @(negedge clk);
        chk("t4_drained", 32'(exp_q.size()), 32'd0);
        chk("t4_count_empty", 32'(count), 32'd0);

        // Bypass: youngest value wins, misses read zero
        wb_en = 1'b0;
        push(4'd4, 16'h000A, 1'b0, 4'd0, 16'h0);
        push(4'd4, 16'h000B, 1'b0, 4'd0, 16'h0);
        chk_reg1 = 4'd4;
        chk_reg2 = 4'd9;
        @(negedge clk);
        chk("t5_hit1", 32'(chk_hit1), 32'd1);
        chk("t5_data1", 32'(chk_data1), 32'h000B);
        chk("t5_hit2", 32'(chk_hit2), 32'd0);
        chk("t5_data2", 32'(chk_data2), 32'd0);
        chk("t5_pending", 32'(pending), 32'h0010);
        @(posedge clk); #1 wb_en = 1'b1;
        @(posedge clk); #1 wb_en = 1'b0;
        @(negedge clk);
        chk("t5_fifo_over_out", 32'(chk_data1), 32'h000B);
        chk("t5_count1", 32'(count), 32'd1);
        @(posedge clk); #1 wb_en = 1'b1;
        repeat (3) @(negedge clk);
        wb_en = 1'b0;
        push(4'd11, 16'hAAAA, 1'b1, 4'd12, 16'h5555);
        chk_reg1 = 4'd11;
        chk_reg2 = 4'd12;
        @(negedge clk);
        chk("t5_port1_data", 32'(chk_data1), 32'hAAAA);
        chk("t5_port2_data", 32'(chk_data2), 32'h5555);
        chk("t5_port2_hit", 32'(chk_hit2), 32'd1);
        wb_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_miss_after", 32'(chk_hit1), 32'd0);
        chk("t5_miss_data", 32'(chk_data1), 32'd0);

        // Streaming push+pop
        seen0 = writes_seen;
        for (int i = 0; i < 10; i++) begin
            push(4'(i), 16'(16'h0100 + i), 1'(i), 4'(15 - i), 16'(16'h0200 + i));
            chk("t6_count", 32'(count), 32'd1);
            if (i > 0) chk("t6_regwrite", 32'(RegWrite), 32'd1);
        end
        repeat (4) @(negedge clk);
        chk("t6_writes", 32'(writes_seen - seen0), 32'd10);
        chk("t6_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
